aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Sequencer for one AES block cipher pass over an external registered round datapath.
//  The datapath covers SubBytes/ShiftRows/MixColumns followed by the registered AddRoundKey stage.
//  Owns the 128-bit state register, round counter and round-key fetch handshake.
//  Drives NR+1 datapath operations per block. Sits between the input/output streams and the
//  round datapath plus key-expansion unit.
// PARAMETERS
//  NR      10  rounds (10/12/14 for AES-128/192/256); round keys are always 128 b
//  DP_LAT  1   cycles from dp_start to valid dp_result (>=1; 1 = registered AddRoundKey)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    reset, asynchronous, active-low
//  in_valid     in   1    plaintext offered
//  in_ready     out  1    controller can accept a block (IDLE)
//  in_data      in   128  plaintext
//  key_req      out  1    round-key request, held until key_ack
//  key_idx      out  4    requested round-key index 0..NR
//  key_ack      in   1    key_data valid this cycle
//  key_data     in   128  round key
//  dp_start     out  1    one-cycle launch pulse to datapath
//  dp_mode      out  2    00 ARK only, 01 full round, 10 final round (no MixColumns)
//  dp_data      out  128  state operand (= state_q)
//  dp_key       out  128  latched round key (= key_q)
//  dp_result    in   128  datapath result
//  out_valid    out  1    ciphertext valid, held until out_ready
//  out_data     out  128  ciphertext (= state_q)
//  out_ready    in   1    downstream accepts
//  busy         out  1    state != IDLE
//  round        out  4    current round 0..NR
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-block): state IDLE; state_q, key_q, round, key_idx,
//   dp_mode = 0; key_req/dp_start/out_valid/busy = 0; in_ready = 1. Operation is abandoned.
//  FSM IDLE->KEY->ISSUE->WAIT->(KEY | DONE)->IDLE.
//  IDLE: in_ready=1. On in_valid: state_q<=in_data, round<=0, goto KEY.
//  KEY: key_req=1, key_idx=round, both stable until key_ack. On key_ack: key_q<=key_data,
//   goto ISSUE. key_ack outside KEY is ignored.
//  ISSUE: dp_start=1 for exactly 1 cycle. dp_mode = 00 when round==0, 10 when round==NR,
//   else 01. Goto WAIT with wait counter = DP_LAT-1.
//  WAIT: dp_data/dp_key/dp_mode held stable. When counter==0: state_q<=dp_result.
//   If round==NR goto DONE; else round<=round+1 and goto KEY. Otherwise decrement counter.
//  DONE: out_valid=1 and out_data stable until out_ready. On out_ready goto IDLE.
//   in_valid is ignored while not IDLE.
//  Latency (key_ack same cycle as key_req): (NR+1)*(2+DP_LAT) cycles from accept to
//   out_valid; 33 cycles for defaults. Each key_ack stall cycle adds 1.
//  Back-to-back: minimum one IDLE cycle between out handshake and next accept.
//  Round counter never exceeds NR and never wraps; width 4 covers NR<=14.
// STRUCTURE
//  aes_pkg holds:
//   - DP_MODE_ARK/FULL/FINAL constants
//   - FSM state encodings (IDLE, KEY, ISSUE, WAIT, DONE)
//   - NR_AES128/192/256
//  No sub-module: single FSM plus state_q/key_q/round/wait-counter registers.
// TESTING
//  Bench uses a behavioural DP_LAT datapath and a key-schedule responder.
//  FIPS-197 App.B: in 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//   -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid 33 cycles after accept.
//  key_ack withheld 3 cycles at round 5 -> key_idx=5 and key_req held; out_valid at 36 cycles;
//   result unchanged.
//  out_ready low 10 cycles in DONE -> out_valid/out_data stable, in_ready=0,
//   in_valid pulses ignored.
//  rst low during WAIT of round 4 -> all outputs at reset values immediately;
//   new block afterwards encrypts correctly.
//  DP_LAT=3 run of App.B vector -> same ciphertext, 55 cycles.
//  dp_mode trace: 00 at round 0, 01 for rounds 1..9, 10 at round 10;
//   exactly 11 dp_start pulses per block.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round sequencer.
// The dp_mode selector is derived from the round number alone.
package aes_pkg;

    localparam logic [1:0] DP_MODE_ARK   = 2'b00;
    localparam logic [1:0] DP_MODE_FULL  = 2'b01;
    localparam logic [1:0] DP_MODE_FINAL = 2'b10;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StIssue,
        StWait,
        StDone
    } ctrl_state_e;

    // Round 0 is the initial whitening, the last round skips MixColumns.
    function automatic logic [1:0] dp_mode_for(input logic [3:0] round, input logic [3:0] last);
        logic [1:0] mode;
        if (round == 4'd0) begin
            mode = DP_MODE_ARK;
        end else if (round == last) begin
            mode = DP_MODE_FINAL;
        end else begin
            mode = DP_MODE_FULL;
        end
        return mode;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for one AES block pass: owns the state and round-key registers, fetches each
// round key, launches the external round datapath and hands the ciphertext downstream.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR     = NR_AES128,
    parameter int unsigned DP_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    output logic         o_key_req,
    output logic [3:0]   o_key_idx,
    input  logic         i_key_ack,
    input  logic [127:0] i_key_data,
    output logic         o_dp_start,
    output logic [1:0]   o_dp_mode,
    output logic [127:0] o_dp_data,
    output logic [127:0] o_dp_key,
    input  logic [127:0] i_dp_result,
    output logic         o_out_valid,
    output logic [127:0] o_out_data,
    input  logic         i_out_ready,
    output logic         o_busy,
    output logic [3:0]   o_round
);

    localparam int unsigned WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DP_LAT - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ctrl_state_e       r_fsm,      w_fsm_next;
    logic [127:0]      r_state,    w_state_next;
    logic [127:0]      r_key,      w_key_next;
    logic [3:0]        r_round,    w_round_next;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm      <= StIdle;
            r_state    <= '0;
            r_key      <= '0;
            r_round    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_state    <= w_state_next;
            r_key      <= w_key_next;
            r_round    <= w_round_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_key_next   = r_key;
        w_round_next = r_round;
        w_wait_next  = r_wait_cnt;
        unique case (r_fsm)
            StIdle: begin
                if (i_in_valid) begin
                    w_state_next = i_in_data;
                    w_round_next = 4'd0;
                    w_fsm_next   = StKey;
                end
            end
            StKey: begin
                if (i_key_ack) begin
                    w_key_next = i_key_data;
                    w_fsm_next = StIssue;
                end
            end
            StIssue: begin
                w_wait_next = WAIT_INIT;
                w_fsm_next  = StWait;
            end
            StWait: begin
                // Result is only sampled once the datapath latency has elapsed.
                if (r_wait_cnt == '0) begin
                    w_state_next = i_dp_result;
                    if (r_round == LAST_ROUND) begin
                        w_fsm_next = StDone;
                    end else begin
                        w_round_next = r_round + 4'd1;
                        w_fsm_next   = StKey;
                    end
                end else begin
                    w_wait_next = r_wait_cnt - 1'b1;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_fsm_next = StIdle;
                end
            end
            default: begin
                w_fsm_next = StIdle;
            end
        endcase
    end

    assign o_in_ready  = (r_fsm == StIdle);
    assign o_key_req   = (r_fsm == StKey);
    assign o_dp_start  = (r_fsm == StIssue);
    assign o_out_valid = (r_fsm == StDone);
    assign o_busy      = (r_fsm != StIdle);
    assign o_key_idx   = r_round;
    assign o_round     = r_round;
    assign o_dp_mode   = dp_mode_for(r_round, LAST_ROUND);
    assign o_dp_data   = r_state;
    assign o_dp_key    = r_key;
    assign o_out_data  = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (DP_LAT 1 and 3) with a behavioural AES round
// datapath and key-schedule responder; ciphertexts come from a whole-block AES-128 model.
module tb_aes_round_ctrl;

    localparam logic [127:0] POISON = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid [2];
    logic         in_ready [2];
    logic [127:0] in_data [2];
    logic         key_req [2];
    logic [3:0]   key_idx [2];
    logic         key_ack [2];
    logic [127:0] key_data [2];
    logic         dp_start [2];
    logic [1:0]   dp_mode [2];
    logic [127:0] dp_data [2];
    logic [127:0] dp_key [2];
    logic [127:0] dp_result [2];
    logic         out_valid [2];
    logic [127:0] out_data [2];
    logic         out_ready [2];
    logic         busy [2];
    logic [3:0]   round [2];

    logic [3:0]   hold_idx [2];
    int           hold_n [2];
    logic [127:0] rk [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ---------------- AES-128 reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, r, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        r = inv; s = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] st, input int i);
        return st[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] st);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(st, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] st);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = gb(st, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] st);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(st, 4*c); a1 = gb(st, 4*c+1); a2 = gb(st, 4*c+2); a3 = gb(st, 4*c+3);
            o[127-32*c -: 8]     = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[127-32*c-8 -: 8]   = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[127-32*c-16 -: 8]  = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[127-32*c-24 -: 8]  = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
        return shift_rows(sub_bytes(s)) ^ rk[10];
    endfunction

    function automatic logic [127:0] dp_op(input logic [1:0] m, input logic [127:0] s,
                                           input logic [127:0] k);
        case (m)
            2'b00:   return s ^ k;
            2'b01:   return mix_columns(shift_rows(sub_bytes(s))) ^ k;
            2'b10:   return shift_rows(sub_bytes(s)) ^ k;
            default: return POISON;
        endcase
    endfunction

    // ---------------- DUTs, datapath models and key responders ----------------
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [127:0] pipe [LAT];
        int stall;

        aes_round_ctrl #(.NR(10), .DP_LAT(LAT)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_in_valid  (in_valid[g]),
            .o_in_ready  (in_ready[g]),
            .i_in_data   (in_data[g]),
            .o_key_req   (key_req[g]),
            .o_key_idx   (key_idx[g]),
            .i_key_ack   (key_ack[g]),
            .i_key_data  (key_data[g]),
            .o_dp_start  (dp_start[g]),
            .o_dp_mode   (dp_mode[g]),
            .o_dp_data   (dp_data[g]),
            .o_dp_key    (dp_key[g]),
            .i_dp_result (dp_result[g]),
            .o_out_valid (out_valid[g]),
            .o_out_data  (out_data[g]),
            .i_out_ready (out_ready[g]),
            .o_busy      (busy[g]),
            .o_round     (round[g])
        );

        always @(posedge clk) begin
            pipe[0] <= dp_start[g] ? dp_op(dp_mode[g], dp_data[g], dp_key[g]) : POISON;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign dp_result[g] = pipe[LAT-1];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) stall <= 0;
            else if (key_req[g] && !key_ack[g]) stall <= stall + 1;
            else stall <= 0;
        end
        assign key_ack[g]  = key_req[g] && ((key_idx[g] != hold_idx[g]) || (stall >= hold_n[g]));
        assign key_data[g] = rk[key_idx[g]];
    end

    // ---------------- monitors on instance 0 ----------------
    logic [1:0] modes0 [$];
    int         nack0, drop0;
    logic       prev_unacked = 1'b0;
    logic [3:0] prev_idx = 4'd0;

    always @(posedge clk) begin
        if (rst_n && dp_start[0]) modes0.push_back(dp_mode[0]);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_unacked && (!key_req[0] || key_idx[0] != prev_idx)) drop0++;
            if (key_req[0] && !key_ack[0]) nack0++;
            prev_unacked = key_req[0] && !key_ack[0];
            prev_idx     = key_idx[0];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input int g);
        chk({tag, "_ctl"}, {in_ready[g], busy[g], key_req[g], dp_start[g], out_valid[g],
                            round[g], key_idx[g], dp_mode[g]}, {1'b1, 14'd0});
        chk({tag, "_out_data"}, out_data[g], '0);
        chk({tag, "_dp_key"}, dp_key[g], '0);
    endtask

    task automatic start_block(input int g, input logic [127:0] pt, input logic [127:0] key);
        int n;
        expand_key(key);
        n = 0;
        while (!in_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", in_ready[g], 1);
        in_data[g]  = pt;
        in_valid[g] = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    task automatic finish_block(input int g, input int out_delay, input logic [127:0] exp_ct,
                                input string tag, output int lat);
        int bad;
        lat = 0;
        while (!out_valid[g] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, out_valid[g], 1);
        chk({tag, "_ct"}, out_data[g], exp_ct);
        bad = 0;
        for (int d = 0; d < out_delay; d++) begin
            in_valid[g] = (d % 2 == 0);
            in_data[g]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (!out_valid[g] || out_data[g] !== exp_ct || in_ready[g] || key_req[g]) bad++;
        end
        in_valid[g] = 1'b0;
        if (out_delay > 0) chk({tag, "_done_hold"}, bad, 0);
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
        chk({tag, "_back_idle"}, {in_ready[g], busy[g], out_valid[g]}, 3'b100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] pt, key, ct_exp;
        int lat, n;

        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
            hold_idx[g] = 4'd15; hold_n[g] = 0;
        end
        nack0 = 0; drop0 = 0;
        #23;
        chk_reset("reset0", 0);
        chk_reset("reset1", 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 Appendix B vector
        modes0.delete();
        start_block(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        finish_block(0, 0, 128'h3925841d02dc09fbdc118597196a0b32, "appb", lat);
        chk("appb_latency", lat, 33);
        chk("appb_n_starts", modes0.size(), 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("appb_mode_r%0d", i), (i < modes0.size()) ? modes0[i] : 2'b11,
                (i == 0) ? 2'b00 : ((i == 10) ? 2'b10 : 2'b01));

        // random blocks
        for (int b = 0; b < 4; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            modes0.delete();
            start_block(0, pt, key);
            ct_exp = aes_ref(pt);
            finish_block(0, 0, ct_exp, $sformatf("rand%0d", b), lat);
            chk($sformatf("rand%0d_latency", b), lat, 33);
            chk($sformatf("rand%0d_n_starts", b), modes0.size(), 11);
        end

        // key_ack withheld 3 cycles at round 5
        hold_idx[0] = 4'd5; hold_n[0] = 3;
        nack0 = 0; drop0 = 0;
        start_block(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        finish_block(0, 0, 128'h3925841d02dc09fbdc118597196a0b32, "stall", lat);
        chk("stall_latency", lat, 36);
        chk("stall_nack_cycles", nack0, 3);
        chk("stall_req_dropped", drop0, 0);
        hold_idx[0] = 4'd15; hold_n[0] = 0;

        // out_ready held low for 10 cycles in DONE
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        start_block(0, pt, key);
        ct_exp = aes_ref(pt);
        finish_block(0, 10, ct_exp, "outhold", lat);
        chk("outhold_latency", lat, 33);

        // asynchronous reset during WAIT of round 4
        start_block(0, {$urandom, $urandom, $urandom, $urandom}, key);
        n = 0;
        while (!(round[0] == 4'd4 && busy[0] && !key_req[0] && !dp_start[0] && !out_valid[0])
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_r4", {round[0], busy[0], key_req[0], dp_start[0]}, {4'd4, 3'b100});
        #2 rst_n = 1'b0;
        #1 chk_reset("midreset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_block(0, pt, key);
        ct_exp = aes_ref(pt);
        finish_block(0, 0, ct_exp, "postreset", lat);
        chk("postreset_latency", lat, 33);

        // DP_LAT = 3 instance on the Appendix B vector
        start_block(1, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        finish_block(1, 0, 128'h3925841d02dc09fbdc118597196a0b32, "lat3", lat);
        chk("lat3_latency", lat, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
